systolic_host_driver: RTL and testbench
=======================================

Name: systolic_host_driver

Overview:
- Host-side initiator for the 4x4 systolic array coprocessor.
- Holds one 4x4 A operand and one 4x4 B operand, loaded through a simple write port.
- On start, it pulses the coprocessor enable, streams A and B bytes in lockstep, waits for the coprocessor's ack, and captures the result byte stream into a 16-entry result buffer the host can read.
- Sits between the host bus logic and the systolic array's serial A/B/out interface.

Parameters:
- DW, 8, data byte width of operands and results
- NE, 16, elements per matrix (4x4, row-major)
- TIMEOUT, 255, max cycles to wait for ack after the feed phase before flagging an error

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_we  in  1  operand write strobe
- cfg_sel  in  1  operand select: 0=A, 1=B
- cfg_addr  in  4  element index, row-major (row*4+col)
- cfg_wdata  in  DW  element value
- start  in  1  single-cycle request to run one multiply
- busy  out  1  high from the cycle after an accepted start until done or err
- done  out  1  one-cycle pulse when the result buffer is complete
- err  out  1  sticky error flag
- res_addr  in  4  result read index
- res_rdata  out  DW  combinational read of result[res_addr]
- sa_en  out  1  coprocessor enable pulse
- sa_a  out  DW  A byte stream to the coprocessor
- sa_b  out  DW  B byte stream to the coprocessor
- sa_out  in  DW  result byte stream from the coprocessor
- sa_ack  in  1  coprocessor result-valid / ack

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State returns to IDLE; idx and timer are cleared.
  - A, B and result buffers are cleared to 0.
  - busy=0, done=0, err=0, sa_en=0, sa_a=0, sa_b=0.
  - A reset mid-operation aborts the run immediately; no done pulse is produced.
- Operand writes:
  - Accepted only in IDLE or ERR.
  - While busy, cfg_we is ignored and the buffers are unchanged.
- FSM states: IDLE, KICK, FEED, WAIT, COLLECT, DONE, ERR.
- IDLE:
  - start=1 goes to KICK next cycle. If cfg_we and start occur in the same cycle, the write is applied first and the start is honoured.
- KICK (1 cycle):
  - sa_en=1, busy=1; idx cleared to 0; the result buffer is not cleared. Next state is FEED.
- FEED (exactly NE cycles):
  - sa_a=A[idx] and sa_b=B[idx] are registered outputs; idx counts 0..15.
  - With start sampled at edge t: sa_en is high in cycle t+1, element 0 appears in cycle t+2, element 15 in cycle t+17.
  - After idx=15, idx clears and the FSM goes to WAIT.
  - sa_ack=1 during FEED is a protocol error and sends the FSM to ERR.
- WAIT:
  - sa_a=sa_b=0. The timer increments each cycle.
  - sa_ack=1 captures sa_out into result[0] in that same cycle, sets idx=1 and moves to COLLECT.
  - If the timer reaches TIMEOUT with no ack, the FSM goes to ERR.
- COLLECT:
  - Each cycle with sa_ack=1, result[idx]=sa_out and idx increments.
  - When the 16th byte is stored, the FSM goes to DONE.
  - sa_ack=0 before 16 bytes have been captured sends the FSM to ERR; bytes already stored are kept.
- DONE (1 cycle):
  - done=1, busy=0 in that cycle, then IDLE.
  - sa_ack still high after the 16th byte is ignored.
- ERR:
  - err=1, busy=0, all sa_* outputs are 0.
  - A new start clears err and goes to KICK; the ack timer is cleared on entry to KICK.
  - rst also clears err.
- start outside IDLE/ERR is ignored; no queuing.
- Reads: res_rdata is always readable; reading during COLLECT returns partially updated data.
- Arithmetic: idx is a 4-bit wrap-free counter, bounded by the FSM. The timer is 8 bits and saturates; no wrap-around.

Test Plan:
- Load A=identity (diagonal 1, else 0), B[i]=i+1; start; model acks 3 cycles after feed with out[i]=i+1 -> sa_en high for 1 cycle, sa_a sequence 1,0,0,0,0,1,..., sa_b sequence 1..16, done pulses once, result[0..15]=1..16, err=0.
- No sa_ack after feed -> err=1 exactly TIMEOUT(255) cycles after entering WAIT, busy=0, sa_a=sa_b=0; the next start clears err and a full run completes.
- sa_ack drops after 7 bytes (values 0x10..0x16) -> err=1, result[0..6]=0x10..0x16, result[7..15] unchanged, no done pulse.
- start and cfg_we (B[3]=0xAA) asserted mid-FEED -> both ignored: the stream is unchanged and B[3] keeps its old value when read back in the next run.
- rst asserted during COLLECT after 5 bytes -> the next cycle shows busy=0, err=0, done=0, all sa_* outputs 0, and all result reads return 0.
- sa_ack=1 during FEED cycle 4 -> ERR entered on the next cycle, streaming stops, err=1.

Source files
------------

// File: rtl/systolic_host_driver.sv
// systolic_host_driver: loads A/B operands, streams them to the 4x4 systolic array
// and collects its 16-byte result stream into a host-readable buffer.
module systolic_host_driver #(
    parameter int DW      = 8,
    parameter int NE      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic          cfg_sel,
    input  logic [3:0]    cfg_addr,
    input  logic [DW-1:0] cfg_wdata,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    input  logic [3:0]    res_addr,
    output logic [DW-1:0] res_rdata,
    output logic          sa_en,
    output logic [DW-1:0] sa_a,
    output logic [DW-1:0] sa_b,
    input  logic [DW-1:0] sa_out,
    input  logic          sa_ack
);
    typedef enum logic [2:0] {IDLE, KICK, FEED, WAIT, COLLECT, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    timer_q, timer_d;
    logic [DW-1:0] sa_a_q, sa_a_d, sa_b_q, sa_b_d;
    logic [DW-1:0] a_q [NE];
    logic [DW-1:0] a_d [NE];
    logic [DW-1:0] b_q [NE];
    logic [DW-1:0] b_d [NE];
    logic [DW-1:0] res_q [NE];
    logic [DW-1:0] res_d [NE];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        sa_a_d  = '0;
        sa_b_d  = '0;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        if (cfg_we && (state_q == IDLE || state_q == ERR)) begin
            if (cfg_sel) b_d[cfg_addr] = cfg_wdata;
            else         a_d[cfg_addr] = cfg_wdata;
        end
        case (state_q)
            IDLE, ERR: begin
                if (start) begin
                    state_d = KICK;
                    timer_d = '0;
                end
            end
            KICK: begin
                idx_d   = '0;
                sa_a_d  = a_q[0];
                sa_b_d  = b_q[0];
                state_d = FEED;
            end
            // sa_a/sa_b are preloaded one cycle ahead so they leave as registers
            FEED: begin
                if (sa_ack) begin
                    state_d = ERR;
                end else if (idx_q == 4'(NE-1)) begin
                    idx_d   = '0;
                    state_d = WAIT;
                end else begin
                    idx_d  = idx_q + 4'd1;
                    sa_a_d = a_q[idx_q + 4'd1];
                    sa_b_d = b_q[idx_q + 4'd1];
                end
            end
            WAIT: begin
                timer_d = (timer_q == '1) ? timer_q : timer_q + 8'd1;
                if (sa_ack) begin
                    res_d[0] = sa_out;
                    idx_d    = 4'd1;
                    state_d  = COLLECT;
                end else if (timer_q == 8'(TIMEOUT-1)) begin
                    state_d = ERR;
                end
            end
            COLLECT: begin
                if (sa_ack) begin
                    res_d[idx_q] = sa_out;
                    idx_d        = idx_q + 4'd1;
                    state_d      = (idx_q == 4'(NE-1)) ? DONE : COLLECT;
                end else begin
                    state_d = ERR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            sa_a_q  <= '0;
            sa_b_q  <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            res_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            sa_a_q  <= sa_a_d;
            sa_b_q  <= sa_b_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    assign busy      = (state_q == KICK) || (state_q == FEED) || (state_q == WAIT) || (state_q == COLLECT);
    assign done      = (state_q == DONE);
    assign err       = (state_q == ERR);
    assign sa_en     = (state_q == KICK);
    assign sa_a      = sa_a_q;
    assign sa_b      = sa_b_q;
    assign res_rdata = res_q[res_addr];
endmodule

// File: tb/tb_systolic_host_driver.sv
// tb_systolic_host_driver: randomized runs of the host driver against a
// matrix/queue level model of operand buffers, streams and result buffer.
module tb_systolic_host_driver;
    logic       clk = 0;
    logic       rst = 1;
    logic       cfg_we = 0, cfg_sel = 0;
    logic [3:0] cfg_addr = 0;
    logic [7:0] cfg_wdata = 0;
    logic       start = 0;
    logic       busy, done, err;
    logic [3:0] res_addr = 0;
    logic [7:0] res_rdata;
    logic       sa_en;
    logic [7:0] sa_a, sa_b;
    logic [7:0] sa_out = 0;
    logic       sa_ack = 0;

    int checks = 0;
    int errors = 0;
    logic [7:0] a_m [16];
    logic [7:0] b_m [16];
    logic [7:0] r_m [16];

    systolic_host_driver dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .start(start), .busy(busy), .done(done), .err(err),
        .res_addr(res_addr), .res_rdata(res_rdata), .sa_en(sa_en), .sa_a(sa_a),
        .sa_b(sa_b), .sa_out(sa_out), .sa_ack(sa_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input logic [7:0] d);
        cfg_we = 1;
        cfg_sel = sel;
        cfg_addr = 4'(addr);
        cfg_wdata = d;
        tick();
        cfg_we = 0;
        if (sel) b_m[addr] = d;
        else a_m[addr] = d;
    endtask

    task automatic load_random();
        for (int i = 0; i < 16; i++) begin
            wr(0, i, 8'($urandom));
            wr(1, i, 8'($urandom));
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            res_addr = 4'(i);
            tick();
            chk(tag, res_rdata, r_m[i]);
        end
    endtask

    task automatic idle_outputs(input string tag, input logic e);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, e);
        chk({tag, "_en"}, sa_en, 0);
        chk({tag, "_a"}, sa_a, 0);
        chk({tag, "_b"}, sa_b, 0);
    endtask

    // nbytes<0: never ack; feed_ack/inj/rst_at<0: disabled
    task automatic run(input int delay, input int nbytes, input int feed_ack, input int inj,
                       input int rst_at, input logic [7:0] base, input bit rnd);
        logic [7:0] v;
        int n;
        start = 1;
        tick();
        start = 0;
        chk("kick_en", sa_en, 1);
        chk("kick_busy", busy, 1);
        chk("kick_err", err, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("feed_a", sa_a, a_m[i]);
            chk("feed_b", sa_b, b_m[i]);
            chk("feed_en", sa_en, 0);
            if (i == feed_ack) begin
                sa_ack = 1;
                tick();
                sa_ack = 0;
                idle_outputs("feedack", 1);
                return;
            end
            if (i == inj) begin
                start = 1;
                cfg_we = 1;
                cfg_sel = 1;
                cfg_addr = 3;
                cfg_wdata = 8'hAA;
            end
            tick();
            start = 0;
            cfg_we = 0;
        end
        chk("wait_a", sa_a, 0);
        chk("wait_b", sa_b, 0);
        chk("wait_busy", busy, 1);
        if (nbytes < 0) begin
            n = 0;
            while (!err && n < 400) begin
                tick();
                n++;
            end
            chk("timeout_cycles", n, 255);
            idle_outputs("timeout", 1);
            return;
        end
        repeat (delay) begin
            tick();
            chk("wait_busy", busy, 1);
        end
        for (int i = 0; i < nbytes; i++) begin
            if (i == rst_at) begin
                sa_ack = 0;
                rst = 1;
                tick();
                rst = 0;
                a_m = '{default: '0};
                b_m = '{default: '0};
                r_m = '{default: '0};
                idle_outputs("rst", 0);
                return;
            end
            v = rnd ? 8'($urandom) : base + 8'(i);
            sa_ack = 1;
            sa_out = v;
            r_m[i] = v;
            chk("col_done", done, 0);
            tick();
        end
        if (nbytes == 16) begin
            chk("done_pulse", done, 1);
            chk("done_busy", busy, 0);
            tick();
            sa_ack = 0;
            idle_outputs("after_done", 0);
        end else begin
            sa_ack = 0;
            tick();
            idle_outputs("drop", 1);
        end
    endtask

    initial begin
        a_m = '{default: '0};
        b_m = '{default: '0};
        r_m = '{default: '0};
        tick();
        tick();
        rst = 0;
        idle_outputs("reset", 0);
        read_all("reset_res");

        for (int i = 0; i < 16; i++) begin
            wr(0, i, (i % 5 == 0) ? 8'd1 : 8'd0);
            wr(1, i, 8'(i + 1));
        end
        run(3, 16, -1, -1, -1, 8'd1, 0);
        read_all("ident_res");

        load_random();
        run(int'($urandom_range(0, 10)), 16, -1, -1, -1, 8'd0, 1);
        read_all("rand_res");

        run(0, -1, -1, -1, -1, 8'd0, 0);
        run(int'($urandom_range(0, 10)), 16, -1, -1, -1, 8'd0, 1);
        read_all("after_err_res");

        run(2, 7, -1, -1, -1, 8'h10, 0);
        read_all("drop_res");

        run(1, 16, -1, 6, -1, 8'd0, 1);
        run(4, 16, -1, -1, -1, 8'd0, 1);
        read_all("inject_res");

        run(0, 16, 4, -1, -1, 8'd0, 0);
        run(5, 16, -1, -1, -1, 8'd0, 1);

        run(2, 16, -1, -1, 5, 8'd0, 1);
        read_all("rst_res");

        for (int k = 0; k < 4; k++) begin
            load_random();
            run(int'($urandom_range(0, 20)), 16, -1, -1, -1, 8'd0, 1);
            read_all("loop_res");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
